// File: rtl/itch_decoder_dispatch_pkg.sv
// rtl/itch_decoder_dispatch_pkg.sv - shared ITCH message-type constants, decoder indices and dispatch state.
package itch_pkg;

  localparam int PAYLOAD_W = 512;

  localparam logic [7:0] MSG_ADD        = 8'h41;
  localparam logic [7:0] MSG_ADD_MPID   = 8'h46;
  localparam logic [7:0] MSG_CANCEL     = 8'h58;
  localparam logic [7:0] MSG_DELETE     = 8'h44;
  localparam logic [7:0] MSG_REPLACE    = 8'h55;
  localparam logic [7:0] MSG_EXEC       = 8'h45;
  localparam logic [7:0] MSG_EXEC_PRICE = 8'h43;

  localparam logic [2:0] DEC_ADD     = 3'd0;
  localparam logic [2:0] DEC_CANCEL  = 3'd1;
  localparam logic [2:0] DEC_DELETE  = 3'd2;
  localparam logic [2:0] DEC_REPLACE = 3'd3;
  localparam logic [2:0] DEC_EXEC    = 3'd4;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } disp_state_t;

  typedef struct packed {
    logic       known;
    logic [2:0] idx;
  } msg_class_t;

  function automatic msg_class_t classify(input logic [7:0] mtype);
    msg_class_t c;
    c = '{known: 1'b1, idx: DEC_ADD};
    case (mtype)
      MSG_ADD, MSG_ADD_MPID:    c.idx = DEC_ADD;
      MSG_CANCEL:               c.idx = DEC_CANCEL;
      MSG_DELETE:               c.idx = DEC_DELETE;
      MSG_REPLACE:              c.idx = DEC_REPLACE;
      MSG_EXEC, MSG_EXEC_PRICE: c.idx = DEC_EXEC;
      default:                  c.known = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/itch_decoder_dispatch_if.sv
// rtl/itch_decoder_dispatch_if.sv - upstream payload handshake and decoder-bank issue/decoded signals.
interface itch_decoder_dispatch_if #(
  parameter int NUM_DEC = 5
);
  import itch_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [PAYLOAD_W-1:0] in_payload;
  logic [NUM_DEC-1:0]   dec_valid;
  logic [PAYLOAD_W-1:0] dec_payload;
  logic [NUM_DEC-1:0]   dec_decoded;

  modport master (
    output in_valid, in_payload, dec_decoded,
    input  in_ready, dec_valid, dec_payload
  );

  modport slave (
    input  in_valid, in_payload, dec_decoded,
    output in_ready, dec_valid, dec_payload
  );
endinterface

// File: rtl/itch_payload_fifo.sv
// rtl/itch_payload_fifo.sv - power-of-two payload FIFO with a registered ready (not full after this edge).
module itch_payload_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 512,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count,
  output logic         ready
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;

  assign rdata     = mem[rd_ptr];
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign count_nxt = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      ready <= (count_nxt != CW'(DEPTH));
    end
  end

endmodule

// File: rtl/itch_decoder_dispatch.sv
// rtl/itch_decoder_dispatch.sv - serialising dispatcher for the ITCH decoder bank.
// Optional event counters msg_cnt/unk_cnt/tmo_cnt under ITCH_DISPATCH_STATS_EN.
module itch_decoder_dispatch
  import itch_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT = 15,
  parameter int NUM_DEC = 5
) (
  input  logic clk,
  input  logic rst_n,
  itch_decoder_dispatch_if.slave bus,
  output logic busy,
  output logic unk_pulse,
  output logic timeout_pulse,
  output logic spur_pulse
`ifdef ITCH_DISPATCH_STATS_EN
  ,
  output logic [31:0] msg_cnt,
  output logic [31:0] unk_cnt,
  output logic [31:0] tmo_cnt
`endif
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  disp_state_t          state;
  logic [NUM_DEC-1:0]   sel_q;
  logic [TW-1:0]        tcnt;
  logic [PAYLOAD_W-1:0] head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [CW-1:0]        cnt_nxt;
  logic                 push, pop, issue, hit, tmo_hit, leave, wait_nxt;
  msg_class_t           cls;
  logic [NUM_DEC-1:0]   sel_onehot;

  assign push       = bus.in_valid && bus.in_ready && !fifo_full;
  assign pop        = (state == ST_IDLE) && !fifo_empty;
  assign cls        = classify(head[PAYLOAD_W-1 -: 8]);
  assign sel_onehot = NUM_DEC'(1) << cls.idx;
  assign issue      = pop && cls.known;
  assign hit        = |(bus.dec_decoded & sel_q);
  assign tmo_hit    = (tcnt == TW'(TIMEOUT - 1));
  assign leave      = (state == ST_WAIT) && (hit || tmo_hit);
  assign wait_nxt   = issue || ((state == ST_WAIT) && !leave);
  assign cnt_nxt    = fifo_count + CW'(push) - CW'(pop);

  itch_payload_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PAYLOAD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (bus.in_payload),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .ready (bus.in_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      sel_q           <= '0;
      tcnt            <= '0;
      bus.dec_valid   <= '0;
      bus.dec_payload <= '0;
      busy            <= 1'b0;
      unk_pulse       <= 1'b0;
      timeout_pulse   <= 1'b0;
      spur_pulse      <= 1'b0;
    end else begin
      bus.dec_valid <= '0;
      unk_pulse     <= 1'b0;
      timeout_pulse <= 1'b0;
      spur_pulse    <= |(bus.dec_decoded & ~sel_q);
      busy          <= wait_nxt || (cnt_nxt != '0);
      case (state)
        ST_IDLE: begin
          if (pop) begin
            if (cls.known) begin
              bus.dec_payload <= head;
              bus.dec_valid   <= sel_onehot;
              sel_q           <= sel_onehot;
              tcnt            <= '0;
              state           <= ST_WAIT;
            end else begin
              unk_pulse <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          tcnt <= tcnt + TW'(1);
          // A decoded pulse landing on the timeout cycle still counts as success.
          if (hit) begin
            state <= ST_IDLE;
          end else if (tmo_hit) begin
            timeout_pulse <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ITCH_DISPATCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_cnt <= '0;
      unk_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      if (issue)                 msg_cnt <= msg_cnt + 32'd1;
      if (pop && !cls.known)     unk_cnt <= unk_cnt + 32'd1;
      if (leave && !hit)         tmo_cnt <= tmo_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_itch_decoder_dispatch.sv
// tb/tb_itch_decoder_dispatch.sv - directed table plus multi-cycle sequences for itch_decoder_dispatch.
module tb_itch_decoder_dispatch;

  logic clk;
  logic rst_n;
  logic busy, unk_pulse, timeout_pulse, spur_pulse;
`ifdef ITCH_DISPATCH_STATS_EN
  logic [31:0] msg_cnt, unk_cnt, tmo_cnt;
`endif

  itch_decoder_dispatch_if #(.NUM_DEC(5)) bus ();

  itch_decoder_dispatch #(
    .FIFO_DEPTH (2),
    .TIMEOUT    (15),
    .NUM_DEC    (5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .busy          (busy),
    .unk_pulse     (unk_pulse),
    .timeout_pulse (timeout_pulse),
    .spur_pulse    (spur_pulse)
`ifdef ITCH_DISPATCH_STATS_EN
    ,
    .msg_cnt       (msg_cnt),
    .unk_cnt       (unk_cnt),
    .tmo_cnt       (tmo_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] mtype;
    logic [4:0] exp_valid;
    logic       exp_unk;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]   seed = 8'h11;
  logic [511:0] last_issued;
  logic [511:0] pushed [3];
  logic [4:0]   vlog [24];
  logic [511:0] dlog [24];
  logic         ulog [24], tlog [24], slog [24], rlog [24], blog [24];

  function automatic logic [511:0] mkpl(input logic [7:0] t, input logic [7:0] s);
    return {t, {63{s}}};
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push up to three payloads on consecutive edges, then log outputs each cycle.
  // auto_dec models a decoder that answers one edge after sampling its valid.
  task automatic run_seq(input int np, input logic [7:0] t0, input logic [7:0] t1,
                         input logic [7:0] t2, input bit auto_dec,
                         input int ik1, input logic [4:0] im1,
                         input int ik2, input logic [4:0] im2, input int ncyc);
    logic [4:0] prev;
    logic [7:0] t;
    prev = '0;
    for (int k = 0; k < ncyc; k++) begin
      if (k < np) begin
        t = (k == 0) ? t0 : (k == 1) ? t1 : t2;
        pushed[k] = mkpl(t, seed);
        seed = seed + 8'd1;
        bus.in_valid   = 1'b1;
        bus.in_payload = pushed[k];
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      vlog[k] = bus.dec_valid;
      dlog[k] = bus.dec_payload;
      ulog[k] = unk_pulse;
      tlog[k] = timeout_pulse;
      slog[k] = spur_pulse;
      rlog[k] = bus.in_ready;
      blog[k] = busy;
      bus.dec_decoded = (auto_dec ? prev : 5'b0) | ((k == ik1) ? im1 : 5'b0)
                      | ((k == ik2) ? im2 : 5'b0);
      prev = bus.dec_valid;
    end
    bus.in_valid    = 1'b0;
    bus.dec_decoded = '0;
  endtask

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{8'h41, 5'b00001, 1'b0};
    tbl[1]  = '{8'h46, 5'b00001, 1'b0};
    tbl[2]  = '{8'h58, 5'b00010, 1'b0};
    tbl[3]  = '{8'h44, 5'b00100, 1'b0};
    tbl[4]  = '{8'h00, 5'b00000, 1'b1};
    tbl[5]  = '{8'h55, 5'b01000, 1'b0};
    tbl[6]  = '{8'h45, 5'b10000, 1'b0};
    tbl[7]  = '{8'h5A, 5'b00000, 1'b1};
    tbl[8]  = '{8'h43, 5'b10000, 1'b0};
    tbl[9]  = '{8'hFF, 5'b00000, 1'b1};
    tbl[10] = '{8'h42, 5'b00000, 1'b1};

    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_payload  = '0;
    bus.dec_decoded = '0;
    last_issued     = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_dec_valid", bus.dec_valid, 0);
    chk("rst_dec_payload", bus.dec_payload, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {unk_pulse, timeout_pulse, spur_pulse}, 0);

    for (int i = 0; i < 11; i++) begin
      logic any_pulse;
      run_seq(1, tbl[i].mtype, 8'h00, 8'h00, 1'b1, -1, 5'b0, -1, 5'b0, 5);
      if (tbl[i].exp_valid != 5'b0) last_issued = pushed[0];
      chk($sformatf("tbl%0d_busy0", i), blog[0], 1);
      chk($sformatf("tbl%0d_valid", i), vlog[1], tbl[i].exp_valid);
      chk($sformatf("tbl%0d_unk", i), ulog[1], tbl[i].exp_unk);
      chk($sformatf("tbl%0d_payload", i), dlog[1], last_issued);
      chk($sformatf("tbl%0d_valid_1cyc", i), vlog[2], 0);
      chk($sformatf("tbl%0d_busy1", i), blog[1], (tbl[i].exp_valid != 5'b0));
      chk($sformatf("tbl%0d_busy_done", i), blog[3], 0);
      any_pulse = 1'b0;
      for (int k = 0; k < 5; k++) any_pulse |= tlog[k] | slog[k] | (k != 1 && ulog[k]);
      chk($sformatf("tbl%0d_no_stray_pulse", i), any_pulse, 0);
    end

    // Back-to-back D, X, E into a depth-2 FIFO.
    run_seq(3, 8'h44, 8'h58, 8'h45, 1'b1, -1, 5'b0, -1, 5'b0, 11);
    chk("b2b_ready_k1", rlog[1], 1);
    chk("b2b_ready_full", rlog[2], 0);
    chk("b2b_ready_still_full", rlog[3], 0);
    chk("b2b_ready_after_pop", rlog[4], 1);
    chk("b2b_strobe_d", vlog[1], 5'b00100);
    chk("b2b_payload_d", dlog[1], pushed[0]);
    chk("b2b_gap2", vlog[2] | vlog[3], 0);
    chk("b2b_strobe_x", vlog[4], 5'b00010);
    chk("b2b_payload_x", dlog[4], pushed[1]);
    chk("b2b_gap5", vlog[5] | vlog[6], 0);
    chk("b2b_strobe_e", vlog[7], 5'b10000);
    chk("b2b_payload_e", dlog[7], pushed[2]);
    chk("b2b_hold_payload", dlog[8], pushed[2]);
    chk("b2b_busy_k8", blog[8], 1);
    chk("b2b_busy_k9", blog[9], 0);
    last_issued = pushed[2];

    // Unknown 'Z' followed immediately by 'U'.
    run_seq(2, 8'h5A, 8'h55, 8'h00, 1'b1, -1, 5'b0, -1, 5'b0, 6);
    chk("zu_unk", ulog[1], 1);
    chk("zu_no_valid", vlog[1], 0);
    chk("zu_payload_kept", dlog[1], last_issued);
    chk("zu_u_strobe", vlog[2], 5'b01000);
    chk("zu_u_payload", dlog[2], pushed[1]);
    chk("zu_unk_once", ulog[2], 0);
    chk("zu_busy_done", blog[4], 0);

    // Timeout with no decoder response.
    run_seq(1, 8'h41, 8'h00, 8'h00, 1'b0, -1, 5'b0, -1, 5'b0, 19);
    chk("tmo_strobe", vlog[1], 5'b00001);
    chk("tmo_not_early", tlog[15], 0);
    chk("tmo_pulse", tlog[16], 1);
    chk("tmo_once", tlog[17], 0);
    chk("tmo_busy_before", blog[15], 1);
    chk("tmo_busy_after", blog[16], 0);
`ifdef ITCH_DISPATCH_STATS_EN
    chk("tmo_cnt", tmo_cnt, 1);
`endif

    // Decoded arriving on the timeout edge wins.
    run_seq(1, 8'h41, 8'h00, 8'h00, 1'b0, 15, 5'b00001, -1, 5'b0, 18);
    chk("race_no_tmo", tlog[16], 0);
    chk("race_busy_after", blog[16], 0);
    chk("race_no_spur", slog[16], 0);

    // Spurious decoded from index 2 while waiting on index 0.
    run_seq(1, 8'h41, 8'h00, 8'h00, 1'b0, 2, 5'b00100, 4, 5'b00001, 8);
    chk("spur_pulse", slog[3], 1);
    chk("spur_once", slog[4], 0);
    chk("spur_still_wait", blog[4], 1);
    chk("spur_done", blog[5], 0);
    chk("spur_no_tmo", tlog[5] | tlog[6], 0);
    chk("spur_sel_no_spur", slog[5], 0);

    // Reset during WAIT with two entries buffered.
    run_seq(3, 8'h41, 8'h44, 8'h45, 1'b0, -1, 5'b0, -1, 5'b0, 4);
    chk("mid_pre_ready", rlog[2], 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", bus.in_ready, 1);
    chk("mid_rst_valid", bus.dec_valid, 0);
    chk("mid_rst_payload", bus.dec_payload, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pulses", {unk_pulse, timeout_pulse, spur_pulse}, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    run_seq(0, 8'h00, 8'h00, 8'h00, 1'b0, -1, 5'b0, -1, 5'b0, 8);
    begin
      logic [4:0] vacc;
      logic       pacc, racc, bacc;
      vacc = '0; pacc = 1'b0; racc = 1'b1; bacc = 1'b0;
      for (int k = 0; k < 8; k++) begin
        vacc |= vlog[k];
        pacc |= ulog[k] | tlog[k] | slog[k];
        racc &= rlog[k];
        bacc |= blog[k];
      end
      chk("post_rst_no_strobe", vacc, 0);
      chk("post_rst_no_pulse", pacc, 0);
      chk("post_rst_ready", racc, 1);
      chk("post_rst_idle", bacc, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
